// File: rtl/mult_share_ctrl_if.sv
// Requester, result and shared-multiplier signals of the multiplier sharing controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface mult_share_ctrl_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]   REQ_VALID;
  logic [4*N_REQ-1:0] REQ_A;
  logic [4*N_REQ-1:0] REQ_B;
  logic [N_REQ-1:0]   REQ_READY;
  logic [3:0]         MUL_A;
  logic [3:0]         MUL_B;
  logic [7:0]         MUL_P;
  logic               RES_VALID;
  logic [7:0]         RES_DATA;
  logic [ID_W-1:0]    RES_ID;
  logic               RES_READY;
  logic               BUSY;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, MUL_P, RES_READY,
    output REQ_READY, MUL_A, MUL_B, RES_VALID, RES_DATA, RES_ID, BUSY
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, MUL_P, RES_READY,
    input  REQ_READY, MUL_A, MUL_B, RES_VALID, RES_DATA, RES_ID, BUSY
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin controller time-sharing one external combinational 4x4 multiplier
// among N_REQ requesters; waits MUL_LAT settle cycles, then returns product and ID.
module mult_share_ctrl #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mult_share_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        opa_q, opa_d;
  logic [3:0]        opb_q, opb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  grant_c;
  logic              grant_any_c;
  logic [ID_W-1:0]   grant_id_c;
  logic [3:0]        grant_a_c;
  logic [3:0]        grant_b_c;

  // Round-robin search starting at ptr_q; only offered in IDLE and outside reset.
  always_comb begin
    grant_c     = '0;
    grant_any_c = 1'b0;
    grant_id_c  = '0;
    grant_a_c   = '0;
    grant_b_c   = '0;
    if (state_q == IDLE && !rst) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (!grant_any_c && bus.REQ_VALID[i] && (i == (32'(ptr_q) + k) % N_REQ)) begin
            grant_any_c = 1'b1;
            grant_c[i]  = 1'b1;
            grant_id_c  = ID_W'(i);
            grant_a_c   = bus.REQ_A[4*i +: 4];
            grant_b_c   = bus.REQ_B[4*i +: 4];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any_c) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; everything holds unless the current state updates it.
  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (grant_any_c) begin
          opa_d = grant_a_c;
          opb_d = grant_b_c;
          id_d  = grant_id_c;
          cnt_d = CNT_W'(MUL_LAT - 1);
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_data_d  = bus.MUL_P;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          ptr_d = (32'(id_q) + 32'd1 >= N_REQ) ? '0 : id_q + ID_W'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.REQ_READY = grant_c;
  assign bus.MUL_A     = opa_q;
  assign bus.MUL_B     = opb_q;
  assign bus.RES_VALID = res_valid_q;
  assign bus.RES_DATA  = res_data_q;
  assign bus.RES_ID    = res_id_q;
  assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: u1 (MUL_LAT=1) for the main function,
// u3 (MUL_LAT=3) for settle latency, u4 (MUL_LAT=4) for reset during CALC.
module tb_mult_share_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.N_REQ(N), .ID_W(IW)) if1 ();
  mult_share_ctrl_if #(.N_REQ(N), .ID_W(IW)) if3 ();
  mult_share_ctrl_if #(.N_REQ(N), .ID_W(IW)) if4 ();

  // Shared multiplier instances modelled as plain products.
  assign if1.MUL_P = 8'(if1.MUL_A) * 8'(if1.MUL_B);
  assign if3.MUL_P = 8'(if3.MUL_A) * 8'(if3.MUL_B);
  assign if4.MUL_P = 8'(if4.MUL_A) * 8'(if4.MUL_B);

  mult_share_ctrl #(.N_REQ(N), .ID_W(IW), .MUL_LAT(1)) u1 (.clk(clk), .rst(rst),  .bus(if1.slave));
  mult_share_ctrl #(.N_REQ(N), .ID_W(IW), .MUL_LAT(3)) u3 (.clk(clk), .rst(rst2), .bus(if3.slave));
  mult_share_ctrl #(.N_REQ(N), .ID_W(IW), .MUL_LAT(4)) u4 (.clk(clk), .rst(rst2), .bus(if4.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete u1 transaction from a single requester, RES_READY held high.
  task automatic do_req(input int id, input int a, input int b);
    if1.REQ_VALID[id]      = 1'b1;
    if1.REQ_A[4*id +: 4]   = 4'(a);
    if1.REQ_B[4*id +: 4]   = 4'(b);
    #1;
    chk("req_grant", 32'(if1.REQ_READY), 32'(1 << id));
    tick();
    if1.REQ_VALID = '0;
    if1.REQ_A     = '1;
    if1.REQ_B     = '1;
    #1;
    chk("calc_ready", 32'(if1.REQ_READY), 0);
    chk("calc_mul_a", 32'(if1.MUL_A), 32'(a));
    chk("calc_mul_b", 32'(if1.MUL_B), 32'(b));
    chk("calc_busy",  32'(if1.BUSY), 1);
    tick();
    chk("res_valid", 32'(if1.RES_VALID), 1);
    chk("res_data",  32'(if1.RES_DATA), 32'(a * b));
    chk("res_id",    32'(if1.RES_ID), 32'(id));
    chk("done_mul_a", 32'(if1.MUL_A), 32'(a));
    tick();
    chk("post_valid", 32'(if1.RES_VALID), 0);
    chk("post_busy",  32'(if1.BUSY), 0);
  endtask

  // One u1 service with whatever requesters are currently valid.
  task automatic svc(input int eid, input int edata);
    #1;
    chk("rr_grant", 32'(if1.REQ_READY), 32'(1 << eid));
    tick();
    tick();
    chk("rr_valid", 32'(if1.RES_VALID), 1);
    chk("rr_data",  32'(if1.RES_DATA), 32'(edata));
    chk("rr_id",    32'(if1.RES_ID), 32'(eid));
    tick();
  endtask

  initial begin
    if1.REQ_VALID = '0; if1.REQ_A = '0; if1.REQ_B = '0; if1.RES_READY = 1'b0;
    if3.REQ_VALID = '0; if3.REQ_A = '0; if3.REQ_B = '0; if3.RES_READY = 1'b0;
    if4.REQ_VALID = '0; if4.REQ_A = '0; if4.REQ_B = '0; if4.RES_READY = 1'b0;

    // Reset, with a request pending that must not be granted.
    if1.REQ_VALID = 4'b0001;
    tick();
    tick();
    chk("rst_ready", 32'(if1.REQ_READY), 0);
    chk("rst_valid", 32'(if1.RES_VALID), 0);
    chk("rst_data",  32'(if1.RES_DATA), 0);
    chk("rst_id",    32'(if1.RES_ID), 0);
    chk("rst_busy",  32'(if1.BUSY), 0);
    chk("rst_mul_a", 32'(if1.MUL_A), 0);
    chk("rst_mul_b", 32'(if1.MUL_B), 0);
    if1.REQ_VALID = '0;
    rst = 1'b0;
    if1.RES_READY = 1'b1;

    // Single request and operand extremes; last two from requester 3 wrap ptr to 0.
    do_req(0, 13, 11);
    do_req(1, 15, 15);
    do_req(2, 0, 9);
    do_req(3, 1, 15);
    do_req(3, 8, 2);

    // Round robin with all four valid, then with only 1 and 3.
    for (int i = 0; i < 4; i++) begin
      if1.REQ_A[4*i +: 4] = 4'(i + 1);
      if1.REQ_B[4*i +: 4] = 4'd3;
    end
    if1.REQ_VALID = 4'b1111;
    svc(0, 3);
    svc(1, 6);
    svc(2, 9);
    svc(3, 12);
    svc(0, 3);
    if1.REQ_VALID = 4'b1010;
    svc(1, 6);
    svc(3, 12);
    svc(1, 6);
    svc(3, 12);
    if1.REQ_VALID = '0;

    // Backpressure: result held five cycles, no second grant meanwhile.
    if1.RES_READY = 1'b0;
    if1.REQ_A[3:0] = 4'd5;  if1.REQ_B[3:0] = 4'd5;
    if1.REQ_A[11:8] = 4'd2; if1.REQ_B[11:8] = 4'd7;
    if1.REQ_VALID = 4'b0101;
    #1;
    chk("bp_grant0", 32'(if1.REQ_READY), 1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(if1.RES_VALID), 1);
      chk("bp_data",  32'(if1.RES_DATA), 25);
      chk("bp_id",    32'(if1.RES_ID), 0);
      chk("bp_ready", 32'(if1.REQ_READY), 0);
      tick();
    end
    if1.RES_READY = 1'b1;
    tick();
    chk("bp_drop", 32'(if1.RES_VALID), 0);
    chk("bp_grant2", 32'(if1.REQ_READY), 4);
    tick();
    tick();
    chk("bp2_valid", 32'(if1.RES_VALID), 1);
    chk("bp2_data",  32'(if1.RES_DATA), 14);
    chk("bp2_id",    32'(if1.RES_ID), 2);
    tick();
    if1.REQ_VALID = '0;

    // Settle latency with MUL_LAT=3: 7*6.
    rst2 = 1'b0;
    if3.RES_READY = 1'b1;
    if4.RES_READY = 1'b1;
    if3.REQ_A[3:0] = 4'd7; if3.REQ_B[3:0] = 4'd6;
    if3.REQ_VALID = 4'b0001;
    #1;
    chk("lat_grant", 32'(if3.REQ_READY), 1);
    tick();
    if3.REQ_VALID = '0;
    chk("lat_v0", 32'(if3.RES_VALID), 0);
    chk("lat_mul_a", 32'(if3.MUL_A), 7);
    chk("lat_mul_b", 32'(if3.MUL_B), 6);
    tick();
    chk("lat_v1", 32'(if3.RES_VALID), 0);
    tick();
    chk("lat_v2", 32'(if3.RES_VALID), 0);
    tick();
    chk("lat_v3", 32'(if3.RES_VALID), 1);
    chk("lat_data", 32'(if3.RES_DATA), 42);
    tick();
    chk("lat_drop", 32'(if3.RES_VALID), 0);

    // MUL_LAT=4: serve requester 1 so ptr moves to 2.
    if4.REQ_A[7:4] = 4'd3; if4.REQ_B[7:4] = 4'd4;
    if4.REQ_VALID = 4'b0010;
    #1;
    chk("m4_grant", 32'(if4.REQ_READY), 2);
    tick();
    if4.REQ_VALID = '0;
    tick();
    tick();
    tick();
    chk("m4_v3", 32'(if4.RES_VALID), 0);
    tick();
    chk("m4_valid", 32'(if4.RES_VALID), 1);
    chk("m4_data",  32'(if4.RES_DATA), 12);
    chk("m4_id",    32'(if4.RES_ID), 1);
    tick();
    chk("m4_drop", 32'(if4.RES_VALID), 0);

    // Reset during CALC abandons requester 2 and returns ptr to 0.
    if4.REQ_A[11:8] = 4'd9; if4.REQ_B[11:8] = 4'd9;
    if4.REQ_VALID = 4'b0100;
    #1;
    chk("mr_grant", 32'(if4.REQ_READY), 4);
    tick();
    if4.REQ_VALID = '0;
    chk("mr_busy", 32'(if4.BUSY), 1);
    tick();
    rst2 = 1'b1;
    if4.REQ_VALID = 4'b1111;
    #1;
    chk("mr_rst_ready", 32'(if4.REQ_READY), 0);
    tick();
    chk("mr_busy0",  32'(if4.BUSY), 0);
    chk("mr_valid0", 32'(if4.RES_VALID), 0);
    chk("mr_data0",  32'(if4.RES_DATA), 0);
    rst2 = 1'b0;
    if4.REQ_A[7:4] = 4'd2;   if4.REQ_B[7:4] = 4'd5;
    if4.REQ_A[15:12] = 4'd1; if4.REQ_B[15:12] = 4'd1;
    if4.REQ_VALID = 4'b1010;
    #1;
    chk("mr_ptr_grant", 32'(if4.REQ_READY), 2);
    tick();
    if4.REQ_VALID = '0;
    tick();
    tick();
    tick();
    chk("mr_v3", 32'(if4.RES_VALID), 0);
    tick();
    chk("mr_valid", 32'(if4.RES_VALID), 1);
    chk("mr_data",  32'(if4.RES_DATA), 10);
    chk("mr_id",    32'(if4.RES_ID), 1);
    tick();
    chk("mr_drop", 32'(if4.RES_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin controller that time-shares one combinational 4x4 array multiplier among N_REQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake and drives the shared multiplier's operand inputs.
- Waits a programmable settle time, then registers the 8-bit product and returns it with the requester ID over a valid/ready result port.
- Sits between the requesting datapath blocks and a single multiplier instance wired externally (MUL_A/MUL_B -> multiplier inputs, multiplier output -> MUL_P).

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of RES_ID; must satisfy 2**ID_W >= N_REQ
- MUL_LAT, 1, settle cycles allowed for the combinational multiplier (1..15; 0 illegal)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- REQ_VALID  in  N_REQ  per-requester operand valid
- REQ_A  in  4*N_REQ  packed multiplicands; requester i at [4i+3:4i]
- REQ_B  in  4*N_REQ  packed multipliers; same packing as REQ_A
- REQ_READY  out  N_REQ  one-hot acceptance; requester i transfers when REQ_VALID[i] & REQ_READY[i]
- MUL_A  out  4  operand A to shared multiplier
- MUL_B  out  4  operand B to shared multiplier
- MUL_P  in  8  product from shared multiplier
- RES_VALID  out  1  result valid
- RES_DATA  out  8  registered product
- RES_ID  out  ID_W  index of the requester that owns RES_DATA
- RES_READY  in  1  consumer accepts result
- BUSY  out  1  high in CALC or DONE

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE, RR pointer=0, operand regs=0, counter=0.
  - RES_VALID=0, RES_DATA=0, RES_ID=0, BUSY=0, MUL_A=MUL_B=0.
  - REQ_READY=0 whenever rst is high.
  - Reset mid-operation abandons the in-flight request with no result.
- States: IDLE, CALC, DONE.
- IDLE:
  - REQ_READY is combinational: one-hot at the first i with REQ_VALID[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - REQ_READY is all-zero if no REQ_VALID bit is set.
  - On the edge with a grant: latch REQ_A/REQ_B slice into operand regs, latch the ID, counter=MUL_LAT-1, go to CALC.
- CALC:
  - REQ_READY=0.
  - MUL_A/MUL_B driven from operand regs; they are stable in all states and hold their last value in IDLE/DONE.
  - While counter != 0, decrement each edge.
  - On the edge with counter==0: RES_DATA<=MUL_P, RES_ID<=latched ID, RES_VALID<=1, go to DONE.
  - Acceptance edge to RES_VALID high = MUL_LAT cycles.
- DONE:
  - RES_VALID=1 with RES_DATA and RES_ID stable until RES_READY=1.
  - On the edge with RES_VALID & RES_READY: RES_VALID<=0, ptr<=(granted ID+1) mod N_REQ, go to IDLE.
  - No new acceptance in that same cycle; the next grant occurs earliest in the following IDLE cycle.
  - Minimum request-to-request spacing is MUL_LAT+2 cycles.
- Fairness:
  - The pointer only advances on result handshake, never on idle cycles.
  - A continuously valid requester waits at most N_REQ-1 other services.
- Requester rules:
  - REQ_VALID may drop without acceptance; the arbiter re-evaluates every IDLE cycle.
  - Operand changes while not accepted have no effect.
- Arithmetic: unsigned 4x4 -> 8 bits; no overflow is possible (max 225).
- BUSY = (state != IDLE).

Test Plan:
- Single request: rst 2 cycles, then requester 0 presents A=13, B=11 with RES_READY=1 → REQ_READY[0] high one cycle; RES_VALID high 1 cycle later (MUL_LAT=1); RES_DATA=143, RES_ID=0; BUSY low after handshake.
- Extremes: 15*15 → 225; 0*9 → 0; 1*15 → 15; 8*2 → 16. Check MUL_A/MUL_B match the latched operands throughout CALC.
- Round robin: all four requesters valid continuously (A=i+1, B=3) → results in ID order 0,1,2,3,0; data 3,6,9,12,3. Repeat with only 1 and 3 valid → order 1,3,1,3.
- Backpressure: RES_READY=0 for 5 cycles after RES_VALID → RES_DATA/RES_ID held constant, REQ_READY all-zero, no second grant; grant resumes the cycle after the handshake plus one.
- Reset mid-op: assert rst in CALC with MUL_LAT=4 → next cycle state IDLE, RES_VALID=0, ptr=0, no result emitted; a fresh request completes normally.
- Latency parameter: MUL_LAT=3, request 7*6 → RES_VALID rises exactly 3 cycles after the acceptance edge, RES_DATA=42.
